// File: rtl/bridge_cmd_mailbox.sv
// bridge_cmd_mailbox: host/core command handshake mailbox with parameter/response files on the APF bridge bus
// Optional core command timeout is built when BRIDGE_CMD_TIMEOUT_EN is defined.
module bridge_cmd_mailbox #(
   parameter int          N_PARAM_WORDS     = 4,
   parameter logic [26:0] HOST_PARAM_OFFSET = 27'h0010000,
   parameter logic [26:0] HOST_RESP_OFFSET  = 27'h0010040,
   parameter logic [26:0] CORE_PARAM_OFFSET = 27'h0010080,
   parameter logic [26:0] CORE_RESP_OFFSET  = 27'h00100C0,
   parameter int          TIMEOUT_CYCLES    = 74_000_000
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        bridge_endian_little,
   input  logic [26:0]                 bridge_addr,
   input  logic                        bridge_wr,
   input  logic                        bridge_rd,
   input  logic [31:0]                 bridge_wr_data,
   output logic [31:0]                 bridge_rd_data,
   output logic                        host_valid,
   output logic [15:0]                 host_word,
   output logic [N_PARAM_WORDS*32-1:0] host_param,
   input  logic                        host_ack,
   input  logic [15:0]                 host_progress,
   input  logic                        host_done,
   input  logic [15:0]                 host_result,
   input  logic [N_PARAM_WORDS*32-1:0] host_response,
   input  logic                        core_valid,
   input  logic [15:0]                 core_word,
   input  logic [N_PARAM_WORDS*32-1:0] core_param,
   output logic                        core_ack,
   output logic                        core_done,
   output logic [15:0]                 core_result,
   output logic [N_PARAM_WORDS*32-1:0] core_response
);
   localparam logic [1:0]  H_IDLE = 2'd0, H_REQ = 2'd1, H_BUSY = 2'd2;
   localparam logic        C_IDLE = 1'b0, C_POSTED = 1'b1;
   localparam logic [15:0] MAGIC_CMD = 16'h434D, MAGIC_BUSY = 16'h6275, MAGIC_OK = 16'h6F6B;
   localparam int          IW = (N_PARAM_WORDS > 1) ? $clog2(N_PARAM_WORDS) : 1;

   // bytes are swapped within each 16-bit half, so command/magic halves keep their position
   function automatic logic [31:0] swap16(input logic [31:0] d);
      return {d[23:16], d[31:24], d[7:0], d[15:8]};
   endfunction

   function automatic logic in_win(input logic [26:0] d);
      return d[26:6] == 21'd0 && 32'(d[5:2]) < N_PARAM_WORDS;
   endfunction

   logic [1:0]                         h_state;
   logic [31:0]                        status;
   logic [N_PARAM_WORDS-1:0][31:0]     hp_q, hr_q, cp_q, cr_q, co_q;
   logic                               c_state;
   logic [31:0]                        c_reg;
   logic [31:0]                        wdata, rd_mux;
   logic [26:0]                        hp_d, hr_d, cp_d, cr_d;
   logic                               hp_hit, hr_hit, cp_hit, cr_hit;
   logic [IW-1:0]                      hp_i, hr_i, cp_i, cr_i;
   logic                               cmd_wr, ok_wr, timeout_hit;

   assign wdata  = bridge_endian_little ? swap16(bridge_wr_data) : bridge_wr_data;
   assign hp_d   = bridge_addr - HOST_PARAM_OFFSET;
   assign hr_d   = bridge_addr - HOST_RESP_OFFSET;
   assign cp_d   = bridge_addr - CORE_PARAM_OFFSET;
   assign cr_d   = bridge_addr - CORE_RESP_OFFSET;
   assign hp_hit = in_win(hp_d);
   assign hr_hit = in_win(hr_d);
   assign cp_hit = in_win(cp_d);
   assign cr_hit = in_win(cr_d);
   assign hp_i   = hp_d[IW+1:2];
   assign hr_i   = hr_d[IW+1:2];
   assign cp_i   = cp_d[IW+1:2];
   assign cr_i   = cr_d[IW+1:2];
   assign cmd_wr = bridge_wr && bridge_addr == 27'h0000 && wdata[31:16] == MAGIC_CMD;
   assign ok_wr  = bridge_wr && bridge_addr == 27'h1000 && wdata[31:16] == MAGIC_OK;

   assign host_valid    = h_state == H_REQ;
   assign host_param    = hp_q;
   assign core_response = co_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_state   <= H_IDLE;
         status    <= '0;
         host_word <= '0;
         hp_q      <= '0;
         hr_q      <= '0;
      end else if (h_state == H_IDLE) begin
         if (cmd_wr) begin
            host_word <= wdata[15:0];
            status    <= {MAGIC_BUSY, 16'h0000};
            h_state   <= H_REQ;
         end
         if (bridge_wr && hp_hit) hp_q[hp_i] <= wdata;
      end else if (host_done && (h_state == H_BUSY || host_ack)) begin
         status  <= {MAGIC_OK, host_result};
         hr_q    <= host_response;
         h_state <= H_IDLE;
      end else if (h_state == H_BUSY) begin
         status <= {MAGIC_BUSY, host_progress};
      end else if (host_ack) begin
         h_state <= H_BUSY;
      end
   end

`ifdef BRIDGE_CMD_TIMEOUT_EN
   logic [31:0] cnt;
   assign timeout_hit = c_state == C_POSTED && cnt == 32'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt <= '0;
      else cnt <= (c_state == C_POSTED && !timeout_hit) ? cnt + 32'd1 : 32'd0;
   end
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         c_state     <= C_IDLE;
         c_reg       <= '0;
         cp_q        <= '0;
         cr_q        <= '0;
         co_q        <= '0;
         core_ack    <= 1'b0;
         core_done   <= 1'b0;
         core_result <= '0;
      end else begin
         core_ack  <= 1'b0;
         core_done <= 1'b0;
         if (c_state == C_IDLE) begin
            if (core_valid) begin
               cp_q     <= core_param;
               c_reg    <= {MAGIC_CMD, core_word};
               core_ack <= 1'b1;
               c_state  <= C_POSTED;
            end
         end else begin
            if (bridge_wr && cr_hit) cr_q[cr_i] <= wdata;
            if (timeout_hit) begin
               core_done   <= 1'b1;
               core_result <= 16'hFFFF;
               co_q        <= '0;
               c_reg       <= '0;
               c_state     <= C_IDLE;
            end else if (ok_wr) begin
               core_done   <= 1'b1;
               core_result <= wdata[15:0];
               co_q        <= cr_q;
               c_reg       <= '0;
               c_state     <= C_IDLE;
            end
         end
      end
   end

   assign rd_mux = bridge_addr == 27'h0000 ? status :
                   bridge_addr == 27'h0004 ? {5'd0, HOST_PARAM_OFFSET} :
                   bridge_addr == 27'h0008 ? {5'd0, HOST_RESP_OFFSET} :
                   bridge_addr == 27'h1000 ? c_reg :
                   bridge_addr == 27'h1004 ? {5'd0, CORE_PARAM_OFFSET} :
                   bridge_addr == 27'h1008 ? {5'd0, CORE_RESP_OFFSET} :
                   hp_hit ? hp_q[hp_i] :
                   hr_hit ? hr_q[hr_i] :
                   cp_hit ? cp_q[cp_i] :
                   cr_hit ? cr_q[cr_i] : 32'hFFFF_FFFF;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) bridge_rd_data <= '0;
      else if (bridge_rd) bridge_rd_data <= bridge_endian_little ? swap16(rd_mux) : rd_mux;
   end
endmodule

// File: doc/bridge_cmd_mailbox.md
Name: bridge_cmd_mailbox

Overview:
- Parametrised bridge command mailbox on the APF bridge bus; successor to the fixed 4-word command register block.
- Runs the host-to-core command handshake (host writes command, core reports busy/progress, then ok/result) and the core-to-host command handshake.
- Provides N_PARAM_WORDS-deep parameter and response register files per direction.
- Sits between the bridge decoder and core command handlers; all register reads are registered.

Parameters:
- N_PARAM_WORDS, 4, 32-bit parameter/response words per direction (1..16).
- HOST_PARAM_OFFSET, 27'h0010000, byte offset of host parameter words.
- HOST_RESP_OFFSET, 27'h0010040, byte offset of host response words.
- CORE_PARAM_OFFSET, 27'h0010080, byte offset of core parameter words.
- CORE_RESP_OFFSET, 27'h00100C0, byte offset of core response words.
- TIMEOUT_CYCLES, 74_000_000, core command timeout (used only with the optional feature).

Ports:
- clk  in  1  bridge clock; the block's single clock.
- reset_n  in  1  asynchronous, active-low reset.
- bridge_endian_little  in  1  byte-swap all bridge data when 1.
- bridge_addr  in  27  bridge address [26:0], already base-decoded.
- bridge_wr  in  1  write strobe.
- bridge_rd  in  1  read strobe.
- bridge_wr_data  in  32  write data.
- bridge_rd_data  out  32  registered read data.
- host_valid  out  1  host command pending toward core.
- host_word  out  16  command word.
- host_param  out  N_PARAM_WORDS*32  parameters; word 0 in LSBs.
- host_ack  in  1  handler accepted.
- host_progress  in  16  busy progress.
- host_done  in  1  completion pulse.
- host_result  in  16  result code.
- host_response  in  N_PARAM_WORDS*32  response words.
- core_valid  in  1  core requests a command to the host.
- core_word  in  16  command word.
- core_param  in  N_PARAM_WORDS*32  parameters.
- core_ack  out  1  one-cycle accept pulse.
- core_done  out  1  one-cycle completion pulse.
- core_result  out  16  host result.
- core_response  out  N_PARAM_WORDS*32  host-written response words.

Behaviour:
- Reset: all outputs and registers 0; both FSMs IDLE.
- Bridge data is byte-swapped in and out when bridge_endian_little=1.
- Read timing: bridge_rd_data is valid 1 cycle after the address.
- Read map: unmapped addresses and parameter index >= N_PARAM_WORDS return 32'hFFFFFFFF.
- 0x0004/0x0008 read HOST_PARAM_OFFSET/HOST_RESP_OFFSET; 0x1004/0x1008 read CORE_PARAM_OFFSET/CORE_RESP_OFFSET.
- Host FSM H_IDLE:
  - A write to 0x0000 with data[31:16]=16'h434D latches data[15:0] to host_word, sets status={16'h6275,16'h0} and moves to H_REQ.
  - A write without the magic value is ignored.
  - Host parameter writes are accepted only in H_IDLE.
- Host FSM H_REQ: host_valid=1 until host_ack.
  - host_ack → H_BUSY.
  - host_ack and host_done in the same cycle → completion directly.
- Host FSM H_BUSY: status={16'h6275,host_progress} every cycle.
- Host completion:
  - On host_done: status={16'h6F6B,host_result}; host_response latched into the host response regs; FSM → H_IDLE.
  - Writes to 0x0000 outside H_IDLE are ignored.
- Reads of 0x0000 return status; status holds its last value in H_IDLE.
- Core FSM C_IDLE: register 0x1000 reads 0.
  - On core_valid: latch core_word/core_param, pulse core_ack, set reg={16'h434D,core_word}, move to C_POSTED.
- Core FSM C_POSTED: the host writes response words at CORE_RESP_OFFSET.
  - A write to 0x1000 with data[31:16]=16'h6F6B pulses core_done, drives core_result=data[15:0], publishes core_response, clears the reg to 0 and returns to C_IDLE.
  - Other data written to 0x1000 is ignored.
- core_valid is ignored outside C_IDLE.
- Simultaneous bridge write and handler event: the handler event wins the status update; the write is still decoded.
- Reset asserted mid-command: both FSMs abort to IDLE with no done pulse.

Optional Feature:
- Macro BRIDGE_CMD_TIMEOUT_EN.
- When defined: a counter runs in C_POSTED. On reaching TIMEOUT_CYCLES it pulses core_done with core_result=16'hFFFF and core_response=0, and returns to C_IDLE. The counter clears on entering C_POSTED.
- When undefined: no counter; C_POSTED waits indefinitely.

Test Plan:
- Write 0x434D0010 to 0x0, handler acks after 3 cycles, progress 0x0005, done with result 0x0000 → host_word=0x0010; status reads 0x62750005 while busy, then 0x6F6B0000.
- Write 0x12340010 to 0x0 → no host_valid; status unchanged.
- N_PARAM_WORDS=8: write 0xA5A5A5A5 to HOST_PARAM_OFFSET+0x1C → host_param[255:224]=0xA5A5A5A5. A read at index 8 returns 0xFFFFFFFF.
- core_valid with word 0x0140 → core_ack for 1 cycle; 0x1000 reads 0x434D0140. Host writes 0x6F6B0002 → core_done for 1 cycle, core_result=0x0002, 0x1000 reads 0.
- bridge_endian_little=1: write 0x4D430100 to 0x0 → host_word=0x0001.
- With BRIDGE_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100: core command posted and not answered → core_done at cycle 100 with result 0xFFFF.
